// File: rtl/sprite_compositor.sv
// Multi-sprite pixel pipeline: double-buffered sprite registers, ROM address generation,
// fixed-priority merge through a writable palette, and per-frame collision reporting.
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPR_W       = 48,
  parameter int unsigned SPR_H       = 48,
  parameter int unsigned NUM_FRAMES  = 16,
  parameter int unsigned PIX_BITS    = 4,
  parameter int unsigned COORD_W     = 10,
  parameter logic [23:0] BG_RGB      = 24'h0,
  localparam int unsigned ADDR_W = $clog2(NUM_FRAMES * SPR_W * SPR_H),
  localparam int unsigned SEL_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int unsigned FRM_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  // One spare bit so out-of-range image indices can be presented and clamped
  localparam int unsigned FIN_W  = FRM_W + 1
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [COORD_W-1:0]              hc,
  input  logic [COORD_W-1:0]              vc,
  input  logic                            is_blanking,
  input  logic                            frame_start,
  input  logic                            spr_wr_en,
  input  logic [SEL_W-1:0]                spr_wr_sel,
  input  logic [COORD_W-1:0]              spr_wr_x,
  input  logic [COORD_W-1:0]              spr_wr_y,
  input  logic [FIN_W-1:0]                spr_wr_frame,
  input  logic                            spr_wr_vis,
  input  logic                            pal_wr_en,
  input  logic [PIX_BITS-1:0]             pal_wr_idx,
  input  logic [23:0]                     pal_wr_rgb,
  output logic [NUM_SPRITES*ADDR_W-1:0]   rom_addr,
  input  logic [NUM_SPRITES*PIX_BITS-1:0] rom_data,
  output logic [7:0]                      red,
  output logic [7:0]                      green,
  output logic [7:0]                      blue,
  output logic [NUM_SPRITES-1:0]          collision_mask
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [FRM_W-1:0]   frame;
    logic               vis;
  } spr_t;

  spr_t shadow_q [NUM_SPRITES];
  spr_t shadow_d [NUM_SPRITES];
  spr_t active_q [NUM_SPRITES];
  spr_t active_d [NUM_SPRITES];

  logic [23:0] pal_q [2**PIX_BITS];
  logic [23:0] pal_d [2**PIX_BITS];

  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [NUM_SPRITES-1:0]        hit0_q, hit0_d, hit1_q, hit1_d;
  logic                          blank0_q, blank0_d, blank1_q, blank1_d;
  logic [NUM_SPRITES-1:0]        coll_acc_q, coll_acc_d, coll_mask_q, coll_mask_d;
  logic [23:0]                   rgb_q, rgb_d;

  logic [FRM_W-1:0]              wr_frame_clamped;
  logic [COORD_W:0]              dx, dy;
  logic [31:0]                   dx32, dy32, addr32;
  logic [NUM_SPRITES-1:0]        opaque, coll_new, others;
  logic [PIX_BITS-1:0]           win_pix;
  int unsigned                   j;

  // Sprite registers and palette; commit copies the pre-write shadow, so a
  // write landing in the frame_start cycle waits for the following commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pal_d    = pal_q;
    wr_frame_clamped = (spr_wr_frame >= FIN_W'(NUM_FRAMES)) ? FRM_W'(NUM_FRAMES - 1)
                                                           : spr_wr_frame[FRM_W-1:0];
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (spr_wr_en && spr_wr_sel == SEL_W'(i))
        shadow_d[i] = '{x: spr_wr_x, y: spr_wr_y, frame: wr_frame_clamped, vis: spr_wr_vis};
    end
    if (frame_start) active_d = shadow_q;
    if (pal_wr_en) pal_d[pal_wr_idx] = pal_wr_rgb;
  end

  // S0: hit test and ROM address per sprite
  always_comb begin
    rom_addr_d = '0;
    hit0_d     = '0;
    dx = '0; dy = '0; dx32 = '0; dy32 = '0; addr32 = '0;
    blank0_d   = is_blanking;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      dx   = {1'b0, hc} - {1'b0, active_q[i].x};
      dy   = {1'b0, vc} - {1'b0, active_q[i].y};
      dx32 = 32'(dx);
      dy32 = 32'(dy);
      hit0_d[i] = active_q[i].vis & ~is_blanking & ~dx[COORD_W] & ~dy[COORD_W]
                & (dx32 < SPR_W) & (dy32 < SPR_H);
      addr32 = 32'(active_q[i].frame) * SPR_W * SPR_H + dy32 * SPR_W + dx32;
      if (hit0_d[i]) rom_addr_d[i*ADDR_W +: ADDR_W] = addr32[ADDR_W-1:0];
    end
    hit1_d   = hit0_q;
    blank1_d = blank0_q;
  end

  // S1: priority merge, colour lookup and collision accumulation
  always_comb begin
    opaque   = '0;
    coll_new = '0;
    others   = '0;
    win_pix  = '0;
    j        = 0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++)
      opaque[i] = hit1_q[i] & (rom_data[i*PIX_BITS +: PIX_BITS] != '0);
    for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
      j = NUM_SPRITES - 1 - k;
      if (opaque[j]) win_pix = rom_data[j*PIX_BITS +: PIX_BITS];
    end
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      others      = opaque;
      others[i]   = 1'b0;
      coll_new[i] = opaque[i] & (|others);
    end
    if (blank1_q)     rgb_d = '0;
    else if (|opaque) rgb_d = pal_q[win_pix];
    else              rgb_d = BG_RGB;
    coll_mask_d = coll_mask_q;
    coll_acc_d  = coll_acc_q | coll_new;
    if (frame_start) begin
      coll_mask_d = coll_acc_q;
      coll_acc_d  = coll_new;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int unsigned i = 0; i < 2**PIX_BITS; i++) pal_q[i] <= '0;
      rom_addr_q  <= '0;
      hit0_q      <= '0;
      hit1_q      <= '0;
      blank0_q    <= 1'b0;
      blank1_q    <= 1'b0;
      coll_acc_q  <= '0;
      coll_mask_q <= '0;
      rgb_q       <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pal_q       <= pal_d;
      rom_addr_q  <= rom_addr_d;
      hit0_q      <= hit0_d;
      hit1_q      <= hit1_d;
      blank0_q    <= blank0_d;
      blank1_q    <= blank1_d;
      coll_acc_q  <= coll_acc_d;
      coll_mask_q <= coll_mask_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign red            = rgb_q[23:16];
  assign green          = rgb_q[15:8];
  assign blue           = rgb_q[7:0];
  assign collision_mask = coll_mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: latency, clipping, priority, commit timing,
// collisions, blanking, frame clamp and asynchronous reset.
module tb_sprite_compositor;

  localparam logic [23:0] BG = 24'h123456;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  hc, vc;
  logic        is_blanking, frame_start, spr_wr_en;
  logic [1:0]  spr_wr_sel;
  logic [9:0]  spr_wr_x, spr_wr_y;
  logic [4:0]  spr_wr_frame;
  logic        spr_wr_vis, pal_wr_en;
  logic [3:0]  pal_wr_idx;
  logic [23:0] pal_wr_rgb;
  logic [63:0] rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  red, green, blue;
  logic [3:0]  collision_mask;
  logic [3:0]  rom_val [4];

  int total = 0;
  int bad   = 0;
  logic [23:0] e, g;

  sprite_compositor #(.BG_RGB(BG)) dut (
    .CLK(CLK), .RESET(RESET), .hc(hc), .vc(vc), .is_blanking(is_blanking),
    .frame_start(frame_start), .spr_wr_en(spr_wr_en), .spr_wr_sel(spr_wr_sel),
    .spr_wr_x(spr_wr_x), .spr_wr_y(spr_wr_y), .spr_wr_frame(spr_wr_frame),
    .spr_wr_vis(spr_wr_vis), .pal_wr_en(pal_wr_en), .pal_wr_idx(pal_wr_idx),
    .pal_wr_rgb(pal_wr_rgb), .rom_addr(rom_addr), .rom_data(rom_data),
    .red(red), .green(green), .blue(blue), .collision_mask(collision_mask)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: each sprite returns a fixed index one cycle after its address
  always @(posedge CLK)
    for (int i = 0; i < 4; i++) rom_data[i*4 +: 4] <= rom_val[i];

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    is_blanking = 1'b1; hc = '0; vc = '0;
    repeat (n) tick();
  endtask

  task automatic wr_spr(input logic [1:0] s, input logic [9:0] x, input logic [9:0] y,
                        input logic [4:0] f, input logic v);
    spr_wr_en = 1'b1; spr_wr_sel = s; spr_wr_x = x; spr_wr_y = y;
    spr_wr_frame = f; spr_wr_vis = v;
    tick();
    spr_wr_en = 1'b0;
  endtask

  task automatic wr_pal(input logic [3:0] idx, input logic [23:0] rgb);
    pal_wr_en = 1'b1; pal_wr_idx = idx; pal_wr_rgb = rgb;
    tick();
    pal_wr_en = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One pixel surrounded by blanking; early = RGB 2 clocks later, got = 3 clocks later
  task automatic px(input logic [9:0] h, input logic [9:0] v, input logic b,
                    output logic [23:0] early, output logic [23:0] got);
    idle(3);
    hc = h; vc = v; is_blanking = b;
    tick();
    is_blanking = 1'b1;
    tick();
    early = {red, green, blue};
    tick();
    got = {red, green, blue};
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) tick();
    total++; if ({red, green, blue} !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=%h", {red, green, blue}, 24'h0); end
    total++; if (collision_mask !== 4'b0) begin bad++; $display("FAIL reset_coll got=%b exp=%b", collision_mask, 4'b0); end
    total++; if (rom_addr !== 64'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", rom_addr, 64'h0); end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    wr_pal(4'd1, 24'hFF0000);
    rom_val[0] = 4'd1;
    wr_spr(2'd0, 10'd100, 10'd50, 5'd0, 1'b1);
    px(10'd100, 10'd50, 1'b0, e, g);
    total++; if (g !== BG) begin bad++; $display("FAIL precommit got=%h exp=%h", g, BG); end
    commit();
    px(10'd100, 10'd50, 1'b0, e, g);
    total++; if (e !== 24'h0) begin bad++; $display("FAIL latency_early got=%h exp=%h", e, 24'h0); end
    total++; if (g !== 24'hFF0000) begin bad++; $display("FAIL hit_topleft got=%h exp=%h", g, 24'hFF0000); end
    px(10'd148, 10'd50, 1'b0, e, g);
    total++; if (g !== BG) begin bad++; $display("FAIL right_clip got=%h exp=%h", g, BG); end
    px(10'd147, 10'd97, 1'b0, e, g);
    total++; if (g !== 24'hFF0000) begin bad++; $display("FAIL hit_botright got=%h exp=%h", g, 24'hFF0000); end
    px(10'd100, 10'd98, 1'b0, e, g);
    total++; if (g !== BG) begin bad++; $display("FAIL bottom_clip got=%h exp=%h", g, BG); end
    px(10'd99, 10'd50, 1'b0, e, g);
    total++; if (g !== BG) begin bad++; $display("FAIL left_clip got=%h exp=%h", g, BG); end
    wr_pal(4'd1, 24'h0000FF);
    px(10'd100, 10'd50, 1'b0, e, g);
    total++; if (g !== 24'h0000FF) begin bad++; $display("FAIL pal_immediate got=%h exp=%h", g, 24'h0000FF); end
    wr_pal(4'd1, 24'hFF0000);
    rom_val[0] = 4'd0;
    px(10'd100, 10'd50, 1'b0, e, g);
    total++; if (g !== BG) begin bad++; $display("FAIL transparent got=%h exp=%h", g, BG); end
    rom_val[0] = 4'd1;
  endtask

  task automatic test_rom_addr();
    wr_spr(2'd0, 10'd100, 10'd50, 5'd3, 1'b1);
    commit();
    is_blanking = 1'b0; hc = 10'd110; vc = 10'd60;
    tick();
    total++; if (rom_addr[15:0] !== 16'd7402) begin bad++; $display("FAIL addr_7402 got=%0d exp=%0d", rom_addr[15:0], 7402); end
    total++; if (rom_addr[31:16] !== 16'd0) begin bad++; $display("FAIL addr_novis got=%0d exp=%0d", rom_addr[31:16], 0); end
    hc = 10'd147; vc = 10'd97;
    tick();
    total++; if (rom_addr[15:0] !== 16'd9215) begin bad++; $display("FAIL addr_last got=%0d exp=%0d", rom_addr[15:0], 9215); end
    hc = 10'd148;
    tick();
    total++; if (rom_addr[15:0] !== 16'd0) begin bad++; $display("FAIL addr_miss got=%0d exp=%0d", rom_addr[15:0], 0); end
    idle(1);
  endtask

  task automatic test_collision();
    wr_pal(4'd2, 24'h00FF00);
    rom_val[1] = 4'd2;
    wr_spr(2'd1, 10'd120, 10'd60, 5'd0, 1'b1);
    commit();
    px(10'd130, 10'd70, 1'b0, e, g);
    total++; if (g !== 24'hFF0000) begin bad++; $display("FAIL priority got=%h exp=%h", g, 24'hFF0000); end
    px(10'd160, 10'd70, 1'b0, e, g);
    total++; if (g !== 24'h00FF00) begin bad++; $display("FAIL spr1_only got=%h exp=%h", g, 24'h00FF00); end
    total++; if (collision_mask !== 4'b0000) begin bad++; $display("FAIL coll_midframe got=%b exp=%b", collision_mask, 4'b0000); end
    wr_spr(2'd1, 10'd300, 10'd60, 5'd0, 1'b1);
    commit();
    total++; if (collision_mask !== 4'b0011) begin bad++; $display("FAIL coll_set got=%b exp=%b", collision_mask, 4'b0011); end
    px(10'd130, 10'd70, 1'b0, e, g);
    total++; if (g !== 24'hFF0000) begin bad++; $display("FAIL moved_spr0 got=%h exp=%h", g, 24'hFF0000); end
    px(10'd310, 10'd70, 1'b0, e, g);
    total++; if (g !== 24'h00FF00) begin bad++; $display("FAIL moved_spr1 got=%h exp=%h", g, 24'h00FF00); end
    total++; if (collision_mask !== 4'b0011) begin bad++; $display("FAIL coll_hold got=%b exp=%b", collision_mask, 4'b0011); end
    commit();
    total++; if (collision_mask !== 4'b0000) begin bad++; $display("FAIL coll_clear got=%b exp=%b", collision_mask, 4'b0000); end
  endtask

  task automatic test_commit_same_cycle();
    frame_start = 1'b1;
    spr_wr_en = 1'b1; spr_wr_sel = 2'd0; spr_wr_x = 10'd200; spr_wr_y = 10'd50;
    spr_wr_frame = 5'd0; spr_wr_vis = 1'b1;
    tick();
    frame_start = 1'b0; spr_wr_en = 1'b0;
    px(10'd100, 10'd50, 1'b0, e, g);
    total++; if (g !== 24'hFF0000) begin bad++; $display("FAIL old_x_used got=%h exp=%h", g, 24'hFF0000); end
    px(10'd200, 10'd50, 1'b0, e, g);
    total++; if (g !== BG) begin bad++; $display("FAIL new_x_early got=%h exp=%h", g, BG); end
    commit();
    px(10'd200, 10'd50, 1'b0, e, g);
    total++; if (g !== 24'hFF0000) begin bad++; $display("FAIL new_x_used got=%h exp=%h", g, 24'hFF0000); end
    px(10'd100, 10'd50, 1'b0, e, g);
    total++; if (g !== BG) begin bad++; $display("FAIL old_x_gone got=%h exp=%h", g, BG); end
  endtask

  task automatic test_blank_clamp();
    px(10'd200, 10'd50, 1'b1, e, g);
    total++; if (g !== 24'h0) begin bad++; $display("FAIL blank_black got=%h exp=%h", g, 24'h0); end
    wr_spr(2'd0, 10'd200, 10'd50, 5'd20, 1'b1);
    commit();
    is_blanking = 1'b0; hc = 10'd200; vc = 10'd50;
    tick();
    total++; if (rom_addr[15:0] !== 16'd34560) begin bad++; $display("FAIL clamp20 got=%0d exp=%0d", rom_addr[15:0], 34560); end
    wr_spr(2'd0, 10'd200, 10'd50, 5'd16, 1'b1);
    commit();
    tick();
    total++; if (rom_addr[15:0] !== 16'd34560) begin bad++; $display("FAIL clamp16 got=%0d exp=%0d", rom_addr[15:0], 34560); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    wr_spr(2'd0, 10'd100, 10'd50, 5'd0, 1'b1);
    wr_spr(2'd1, 10'd120, 10'd60, 5'd0, 1'b1);
    commit();
    px(10'd130, 10'd70, 1'b0, e, g);
    commit();
    total++; if (collision_mask !== 4'b0011) begin bad++; $display("FAIL pre_reset_coll got=%b exp=%b", collision_mask, 4'b0011); end
    is_blanking = 1'b0; hc = 10'd130; vc = 10'd70;
    repeat (4) tick();
    total++; if ({red, green, blue} !== 24'hFF0000) begin bad++; $display("FAIL pre_reset_rgb got=%h exp=%h", {red, green, blue}, 24'hFF0000); end
    #3 RESET = 1'b0;
    #1;
    total++; if ({red, green, blue} !== 24'h0) begin bad++; $display("FAIL async_rgb got=%h exp=%h", {red, green, blue}, 24'h0); end
    total++; if (collision_mask !== 4'b0) begin bad++; $display("FAIL async_coll got=%b exp=%b", collision_mask, 4'b0); end
    total++; if (rom_addr !== 64'h0) begin bad++; $display("FAIL async_addr got=%h exp=%h", rom_addr, 64'h0); end
    tick();
    RESET = 1'b1;
    repeat (4) tick();
    total++; if ({red, green, blue} !== BG) begin bad++; $display("FAIL post_reset_vis got=%h exp=%h", {red, green, blue}, BG); end
    total++; if (rom_addr !== 64'h0) begin bad++; $display("FAIL post_reset_addr got=%h exp=%h", rom_addr, 64'h0); end
    commit();
    repeat (4) tick();
    total++; if ({red, green, blue} !== BG) begin bad++; $display("FAIL shadow_cleared got=%h exp=%h", {red, green, blue}, BG); end
    idle(2);
  endtask

  initial begin
    RESET = 1'b0; hc = '0; vc = '0; is_blanking = 1'b1; frame_start = 1'b0;
    spr_wr_en = 1'b0; spr_wr_sel = '0; spr_wr_x = '0; spr_wr_y = '0;
    spr_wr_frame = '0; spr_wr_vis = 1'b0;
    pal_wr_en = 1'b0; pal_wr_idx = '0; pal_wr_rgb = '0;
    for (int i = 0; i < 4; i++) rom_val[i] = 4'd0;
    test_reset();
    test_basic();
    test_rom_addr();
    test_collision();
    test_commit_same_cycle();
    test_blank_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
